// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with operand forwarding muxes, flush/hold control and
// optional bubble/hold performance counters (enabled by defining ID_EX_PERF_CNT_EN).
module id_ex_stage_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic        reg_DE_EN,
   input  logic        reg_DE_flush,
   input  logic        valid_ID,
   input  logic [31:0] PC_ID,
   input  logic [31:0] inst_ID,
   input  logic [31:0] imm_ID,
   input  logic [4:0]  rs1_ID,
   input  logic [4:0]  rs2_ID,
   input  logic [4:0]  rd_ID,
   input  logic [31:0] rs1_data_ID,
   input  logic [31:0] rs2_data_ID,
   input  logic        reg_write_ID,
   input  logic        DatatoReg_ID,
   input  logic        mem_w_ID,
   input  logic        ALUSrc_B_ID,
   input  logic [3:0]  ALU_ctrl_ID,
   input  logic [1:0]  forward_ctrl_A,
   input  logic [1:0]  forward_ctrl_B,
   input  logic [31:0] ALUout_EXE,
   input  logic [31:0] ALUout_MEM,
   input  logic [31:0] Datain_MEM,
   output logic [31:0] PC_EXE,
   output logic [31:0] inst_EXE,
   output logic [31:0] imm_EXE,
   output logic [31:0] rs1_data_EXE,
   output logic [31:0] rs2_data_EXE,
   output logic [4:0]  rs1_EXE,
   output logic [4:0]  rs2_EXE,
   output logic [4:0]  rd_EXE,
   output logic        reg_write_EXE,
   output logic        DatatoReg_EXE,
   output logic        mem_w_EXE,
   output logic        ALUSrc_B_EXE,
   output logic        valid_EXE,
   output logic [3:0]  ALU_ctrl_EXE,
   output logic [31:0] bubble_cnt,
   output logic [31:0] hold_cnt
);

   // addi x0, x0, 0 -- the canonical RISC-V NOP occupies a bubble slot
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        bubble;
   logic        hold;

   always_comb begin
      // NOTE: assign defaults before the case so no path leaves op_a/op_b unassigned (no latch).
      op_a = rs1_data_ID;
      op_b = rs2_data_ID;
      case (forward_ctrl_A)
         2'b01:   op_a = ALUout_EXE;
         2'b10:   op_a = ALUout_MEM;
         2'b11:   op_a = Datain_MEM;
         default: op_a = rs1_data_ID;
      endcase
      case (forward_ctrl_B)
         2'b01:   op_b = ALUout_EXE;
         2'b10:   op_b = ALUout_MEM;
         2'b11:   op_b = Datain_MEM;
         default: op_b = rs2_data_ID;
      endcase
   end

   // Flush beats a stall; a load of an invalid ID slot degenerates into a bubble.
   assign bubble = reg_DE_flush | (reg_DE_EN & ~valid_ID);
   assign hold   = ~reg_DE_flush & ~reg_DE_EN;

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         PC_EXE        <= '0;
         inst_EXE      <= NOP_INST;
         imm_EXE       <= '0;
         rs1_data_EXE  <= '0;
         rs2_data_EXE  <= '0;
         rs1_EXE       <= '0;
         rs2_EXE       <= '0;
         rd_EXE        <= '0;
         reg_write_EXE <= 1'b0;
         DatatoReg_EXE <= 1'b0;
         mem_w_EXE     <= 1'b0;
         ALUSrc_B_EXE  <= 1'b0;
         valid_EXE     <= 1'b0;
         ALU_ctrl_EXE  <= '0;
      end else if (bubble) begin
         // PC still tracks the ID slot so a squashed instruction keeps its address.
         PC_EXE        <= PC_ID;
         inst_EXE      <= NOP_INST;
         imm_EXE       <= '0;
         rs1_data_EXE  <= '0;
         rs2_data_EXE  <= '0;
         rs1_EXE       <= '0;
         rs2_EXE       <= '0;
         rd_EXE        <= '0;
         reg_write_EXE <= 1'b0;
         DatatoReg_EXE <= 1'b0;
         mem_w_EXE     <= 1'b0;
         ALUSrc_B_EXE  <= 1'b0;
         valid_EXE     <= 1'b0;
         ALU_ctrl_EXE  <= '0;
      end else if (reg_DE_EN) begin
         PC_EXE        <= PC_ID;
         inst_EXE      <= inst_ID;
         imm_EXE       <= imm_ID;
         rs1_data_EXE  <= op_a;
         rs2_data_EXE  <= op_b;
         rs1_EXE       <= rs1_ID;
         rs2_EXE       <= rs2_ID;
         rd_EXE        <= rd_ID;
         reg_write_EXE <= reg_write_ID;
         DatatoReg_EXE <= DatatoReg_ID;
         mem_w_EXE     <= mem_w_ID;
         ALUSrc_B_EXE  <= ALUSrc_B_ID;
         valid_EXE     <= valid_ID;
         ALU_ctrl_EXE  <= ALU_ctrl_ID;
      end
   end

`ifdef ID_EX_PERF_CNT_EN
   logic [31:0] bubble_cnt_q;
   logic [31:0] hold_cnt_q;

   // Saturating counters; written only when they advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bubble_cnt_q <= '0;
         hold_cnt_q   <= '0;
      end else begin
         if (bubble && (bubble_cnt_q != 32'hFFFF_FFFF))
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
         if (hold && (hold_cnt_q != 32'hFFFF_FFFF))
            hold_cnt_q <= hold_cnt_q + 32'd1;
      end
   end

   assign bubble_cnt = bubble_cnt_q;
   assign hold_cnt   = hold_cnt_q;
`else
   assign bubble_cnt = '0;
   assign hold_cnt   = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed vector table, hand sequences for
// reset/stall/hold/saturation, and a randomized run against a rule-level reference model.
module tb_id_ex_stage_reg;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        reg_DE_EN, reg_DE_flush, valid_ID;
   logic [31:0] PC_ID, inst_ID, imm_ID;
   logic [4:0]  rs1_ID, rs2_ID, rd_ID;
   logic [31:0] rs1_data_ID, rs2_data_ID;
   logic        reg_write_ID, DatatoReg_ID, mem_w_ID, ALUSrc_B_ID;
   logic [3:0]  ALU_ctrl_ID;
   logic [1:0]  forward_ctrl_A, forward_ctrl_B;
   logic [31:0] ALUout_EXE, ALUout_MEM, Datain_MEM;
   logic [31:0] PC_EXE, inst_EXE, imm_EXE, rs1_data_EXE, rs2_data_EXE;
   logic [4:0]  rs1_EXE, rs2_EXE, rd_EXE;
   logic        reg_write_EXE, DatatoReg_EXE, mem_w_EXE, ALUSrc_B_EXE, valid_EXE;
   logic [3:0]  ALU_ctrl_EXE;
   logic [31:0] bubble_cnt, hold_cnt;

   always #5 clk = ~clk;

   id_ex_stage_reg dut (
      .clk(clk), .rst(rst), .reg_DE_EN(reg_DE_EN), .reg_DE_flush(reg_DE_flush),
      .valid_ID(valid_ID), .PC_ID(PC_ID), .inst_ID(inst_ID), .imm_ID(imm_ID),
      .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
      .rs1_data_ID(rs1_data_ID), .rs2_data_ID(rs2_data_ID),
      .reg_write_ID(reg_write_ID), .DatatoReg_ID(DatatoReg_ID), .mem_w_ID(mem_w_ID),
      .ALUSrc_B_ID(ALUSrc_B_ID), .ALU_ctrl_ID(ALU_ctrl_ID),
      .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
      .ALUout_EXE(ALUout_EXE), .ALUout_MEM(ALUout_MEM), .Datain_MEM(Datain_MEM),
      .PC_EXE(PC_EXE), .inst_EXE(inst_EXE), .imm_EXE(imm_EXE),
      .rs1_data_EXE(rs1_data_EXE), .rs2_data_EXE(rs2_data_EXE),
      .rs1_EXE(rs1_EXE), .rs2_EXE(rs2_EXE), .rd_EXE(rd_EXE),
      .reg_write_EXE(reg_write_EXE), .DatatoReg_EXE(DatatoReg_EXE), .mem_w_EXE(mem_w_EXE),
      .ALUSrc_B_EXE(ALUSrc_B_EXE), .valid_EXE(valid_EXE), .ALU_ctrl_EXE(ALU_ctrl_EXE),
      .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
   );

   // Expected EXE-slot contents, kept as one record.
   typedef struct {
      logic [31:0] pc, inst, imm, a, b;
      logic [4:0]  rs1, rs2, rd;
      logic        rw, d2r, mw, srcb, valid;
      logic [3:0]  alu;
   } slot_t;

   typedef struct {
      logic        en, flush, valid;
      logic [1:0]  fa, fb;
      logic [31:0] pc, inst;
      logic [31:0] e_pc, e_inst, e_a, e_b;
      logic        e_valid, e_rw;
   } vec_t;

   slot_t       m;
   logic [31:0] m_bub, m_hold;
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic slot_t empty_slot(input logic [31:0] pc);
      slot_t s;
      s = '{pc: pc, inst: NOP, imm: 0, a: 0, b: 0, rs1: 0, rs2: 0, rd: 0,
            rw: 0, d2r: 0, mw: 0, srcb: 0, valid: 0, alu: 0};
      return s;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Reference rules: flush or invalid load -> bubble; EN low -> keep; else load.
   task automatic model_edge();
      logic [31:0] src_a [4];
      logic [31:0] src_b [4];
      logic        is_bubble;
      src_a = '{rs1_data_ID, ALUout_EXE, ALUout_MEM, Datain_MEM};
      src_b = '{rs2_data_ID, ALUout_EXE, ALUout_MEM, Datain_MEM};
      is_bubble = reg_DE_flush || (reg_DE_EN && !valid_ID);
`ifdef ID_EX_PERF_CNT_EN
      if (is_bubble) m_bub = sat_inc(m_bub);
      if (!reg_DE_EN && !reg_DE_flush) m_hold = sat_inc(m_hold);
`endif
      if (is_bubble) m = empty_slot(PC_ID);
      else if (reg_DE_EN)
         m = '{pc: PC_ID, inst: inst_ID, imm: imm_ID,
               a: src_a[forward_ctrl_A], b: src_b[forward_ctrl_B],
               rs1: rs1_ID, rs2: rs2_ID, rd: rd_ID, rw: reg_write_ID, d2r: DatatoReg_ID,
               mw: mem_w_ID, srcb: ALUSrc_B_ID, valid: valid_ID, alu: ALU_ctrl_ID};
   endtask

   task automatic model_reset();
      m = empty_slot(32'h0);
      m_bub = 0;
      m_hold = 0;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".PC"},   PC_EXE,       m.pc);
      check({tag, ".inst"}, inst_EXE,     m.inst);
      check({tag, ".imm"},  imm_EXE,      m.imm);
      check({tag, ".a"},    rs1_data_EXE, m.a);
      check({tag, ".b"},    rs2_data_EXE, m.b);
      check({tag, ".idx"},  {17'd0, rs1_EXE, rs2_EXE, rd_EXE}, {17'd0, m.rs1, m.rs2, m.rd});
      check({tag, ".ctl"},  {23'd0, reg_write_EXE, DatatoReg_EXE, mem_w_EXE, ALUSrc_B_EXE,
                             valid_EXE, ALU_ctrl_EXE},
                            {23'd0, m.rw, m.d2r, m.mw, m.srcb, m.valid, m.alu});
      check({tag, ".bubble_cnt"}, bubble_cnt, m_bub);
      check({tag, ".hold_cnt"},   hold_cnt,   m_hold);
   endtask

   task automatic rand_inputs();
      PC_ID = $urandom;  inst_ID = $urandom;  imm_ID = $urandom;
      rs1_ID = 5'($urandom); rs2_ID = 5'($urandom); rd_ID = 5'($urandom);
      rs1_data_ID = $urandom; rs2_data_ID = $urandom;
      reg_write_ID = 1'($urandom); DatatoReg_ID = 1'($urandom);
      mem_w_ID = 1'($urandom); ALUSrc_B_ID = 1'($urandom);
      ALU_ctrl_ID = 4'($urandom);
      forward_ctrl_A = 2'($urandom); forward_ctrl_B = 2'($urandom);
      ALUout_EXE = $urandom; ALUout_MEM = $urandom; Datain_MEM = $urandom;
   endtask

   initial begin
      vec_t        vecs [8];
      slot_t       snap;
      logic [31:0] bub0, hold0;

      vecs[0] = '{1, 0, 1, 2'd0, 2'd0, 32'h100, 32'h002081B3, 32'h100, 32'h002081B3, 1, 1, 1, 1};
      vecs[1] = '{1, 0, 1, 2'd1, 2'd2, 32'h104, 32'h00110113, 32'h104, 32'h00110113, 2, 3, 1, 1};
      vecs[2] = '{1, 0, 1, 2'd2, 2'd3, 32'h108, 32'h00318193, 32'h108, 32'h00318193, 3, 4, 1, 1};
      vecs[3] = '{1, 0, 1, 2'd3, 2'd1, 32'h10C, 32'h00420213, 32'h10C, 32'h00420213, 4, 2, 1, 1};
      vecs[4] = '{1, 1, 1, 2'd1, 2'd1, 32'h200, 32'h00A00093, 32'h200, NOP, 0, 0, 0, 0};
      vecs[5] = '{0, 1, 1, 2'd2, 2'd2, 32'h204, 32'h00A00093, 32'h204, NOP, 0, 0, 0, 0};
      vecs[6] = '{1, 0, 0, 2'd3, 2'd3, 32'h208, 32'h00A00093, 32'h208, NOP, 0, 0, 0, 0};
      vecs[7] = '{0, 0, 1, 2'd1, 2'd1, 32'h20C, 32'h12345678, 32'h208, NOP, 0, 0, 0, 0};

      // Reset is asserted at time zero, before any clock edge.
      rst = 1'b1;
      reg_DE_EN = 1'b1; reg_DE_flush = 1'b0; valid_ID = 1'b1;
      rand_inputs();
      model_reset();
      #2;
      check_all("reset");
      #10;
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed table: forwarding sweep, flush, flush+stall, invalid load, hold.
      rs1_data_ID = 1; rs2_data_ID = 1; ALUout_EXE = 2; ALUout_MEM = 3; Datain_MEM = 4;
      reg_write_ID = 1'b1;
      for (int i = 0; i < 8; i++) begin
         reg_DE_EN = vecs[i].en; reg_DE_flush = vecs[i].flush; valid_ID = vecs[i].valid;
         forward_ctrl_A = vecs[i].fa; forward_ctrl_B = vecs[i].fb;
         PC_ID = vecs[i].pc; inst_ID = vecs[i].inst;
         tick();
         check($sformatf("vec%0d.PC", i),   PC_EXE,        vecs[i].e_pc);
         check($sformatf("vec%0d.inst", i), inst_EXE,      vecs[i].e_inst);
         check($sformatf("vec%0d.a", i),    rs1_data_EXE,  vecs[i].e_a);
         check($sformatf("vec%0d.b", i),    rs2_data_EXE,  vecs[i].e_b);
         check($sformatf("vec%0d.valid", i), {31'd0, valid_EXE}, {31'd0, vecs[i].e_valid});
         check($sformatf("vec%0d.rw", i),    {31'd0, reg_write_EXE}, {31'd0, vecs[i].e_rw});
      end
      check_all("table_end");

      // Hold: load a real instruction, then stall three cycles while inputs churn.
      reg_DE_EN = 1'b1; reg_DE_flush = 1'b0; valid_ID = 1'b1;
      rand_inputs(); inst_ID = 32'h002081B3;
      tick();
      snap = m; hold0 = hold_cnt; bub0 = bubble_cnt;
      check("hold.load_inst", inst_EXE, 32'h002081B3);
      reg_DE_EN = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rand_inputs();
         tick();
         check($sformatf("hold%0d.inst", i), inst_EXE, snap.inst);
         check($sformatf("hold%0d.a", i),    rs1_data_EXE, snap.a);
         check($sformatf("hold%0d.PC", i),   PC_EXE, snap.pc);
      end
`ifdef ID_EX_PERF_CNT_EN
      check("hold.hold_cnt", hold_cnt, hold0 + 32'd3);
`else
      check("hold.hold_cnt", hold_cnt, 32'd0);
`endif
      check_all("hold_end");

      // Load-use stall style flush, and flush that coincides with EN low.
      reg_DE_EN = 1'b1; reg_DE_flush = 1'b1; valid_ID = 1'b1;
      rand_inputs(); inst_ID = 32'h00A00093; reg_write_ID = 1'b1; PC_ID = 32'h300;
      tick();
      check("stall.inst", inst_EXE, NOP);
      check("stall.rw",   {31'd0, reg_write_EXE}, 32'd0);
      check("stall.PC",   PC_EXE, 32'h300);
      bub0 = bubble_cnt; hold0 = hold_cnt;
      reg_DE_EN = 1'b0; reg_DE_flush = 1'b1;
      rand_inputs();
      tick();
      check("flush_en0.inst", inst_EXE, NOP);
`ifdef ID_EX_PERF_CNT_EN
      check("flush_en0.bubble_cnt", bubble_cnt, bub0 + 32'd1);
`else
      check("flush_en0.bubble_cnt", bubble_cnt, 32'd0);
`endif
      check("flush_en0.hold_cnt", hold_cnt, hold0);
      check_all("flush_en0");

      // Randomized run against the reference model.
      for (int i = 0; i < 300; i++) begin
         rand_inputs();
         reg_DE_EN    = ($urandom_range(0, 99) < 75);
         reg_DE_flush = ($urandom_range(0, 99) < 20);
         valid_ID     = ($urandom_range(0, 99) < 80);
         tick();
         check_all($sformatf("rand%0d", i));
      end

`ifdef ID_EX_PERF_CNT_EN
      // Saturation: preload the bubble counter near its ceiling, then flush twice.
      reg_DE_EN = 1'b1; reg_DE_flush = 1'b0; valid_ID = 1'b1;
      force dut.bubble_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.bubble_cnt_q;
      m_bub = 32'hFFFF_FFFE;
      reg_DE_flush = 1'b1;
      tick();
      tick();
      check("sat.bubble_cnt", bubble_cnt, 32'hFFFF_FFFF);
`endif

      // Reset mid-run: load PC 0x100, then assert reset between edges.
      reg_DE_EN = 1'b1; reg_DE_flush = 1'b0; valid_ID = 1'b1;
      rand_inputs(); PC_ID = 32'h100;
      tick();
      check("midrst.load_PC", PC_EXE, 32'h100);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      #1;
      check("midrst.PC",   PC_EXE,   32'h0);
      check("midrst.inst", inst_EXE, NOP);
      check_all("midrst");
      @(negedge clk);
      rst = 1'b0;
      PC_ID = 32'h400;
      tick();
      check("post_rst.PC", PC_EXE, 32'h400);
      check_all("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/id_ex_stage_reg.md
ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 reg_DE_EN  input  1  ID/EX load enable from hazard unit; 0 = hold.
REQ-004 reg_DE_flush  input  1  convert the ID slot into a bubble on next edge.
REQ-005 valid_ID  input  1  ID slot holds a real instruction.
REQ-006 PC_ID, inst_ID, imm_ID  input  32 each  ID-stage PC, instruction word, decoded immediate.
REQ-007 rs1_ID, rs2_ID, rd_ID  input  5 each  ID register indices.
REQ-008 rs1_data_ID, rs2_data_ID  input  32 each  register-file read data.
REQ-009 reg_write_ID, DatatoReg_ID, mem_w_ID, ALUSrc_B_ID  input  1 each  ID control bits.
REQ-010 ALU_ctrl_ID  input  4  ALU operation select.
REQ-011 forward_ctrl_A, forward_ctrl_B  input  2 each  operand source select from hazard unit.
REQ-012 ALUout_EXE, ALUout_MEM, Datain_MEM  input  32 each  forwarding sources.
REQ-013 PC_EXE, inst_EXE, imm_EXE, rs1_data_EXE, rs2_data_EXE  output  32 each  registered ID values, operands post-forwarding.
REQ-014 rs1_EXE, rs2_EXE, rd_EXE  output  5 each  registered indices.
REQ-015 reg_write_EXE, DatatoReg_EXE, mem_w_EXE, ALUSrc_B_EXE, valid_EXE  output  1 each  registered control.
REQ-016 ALU_ctrl_EXE  output  4  registered ALU select.
REQ-017 bubble_cnt, hold_cnt  output  32 each  performance counters (see Configuration).

Function
REQ-018 Operand A mux (combinational, pre-register): forward_ctrl_A 00 -> rs1_data_ID, 01 -> ALUout_EXE, 10 -> ALUout_MEM, 11 -> Datain_MEM; operand B identical using forward_ctrl_B and rs2_data_ID.
REQ-019 Priority per edge: rst > reg_DE_flush > (reg_DE_EN==0 hold) > load.
REQ-020 Load: every *_EXE output takes its ID input (operands take mux result) on the edge; latency exactly 1 cycle.
REQ-021 Flush: inst_EXE = 32'h00000013, valid_EXE, reg_write_EXE, DatatoReg_EXE, mem_w_EXE, ALUSrc_B_EXE = 0, ALU_ctrl_EXE = 0, rd/rs1/rs2_EXE = 0, operands and imm = 0; PC_EXE = PC_ID.
REQ-022 Flush with reg_DE_EN==0 in same cycle: flush wins.
REQ-023 Hold: all outputs retain value; forwarding mux result discarded.
REQ-024 valid_ID==0 on load: treated as flush (bubble) except PC_EXE loads PC_ID.
REQ-025 No combinational path from any input to any output.

Reset
REQ-026 rst asserted: immediately (no clock) all outputs 0 except inst_EXE = 32'h00000013; counters 0.
REQ-027 rst deasserted: first rising edge after deassertion follows REQ-019 normally.

Configuration
REQ-028 Macro ID_EX_PERF_CNT_EN defined: bubble_cnt increments on each edge where reg_DE_flush==1 or a valid_ID==0 load occurs; hold_cnt increments on each edge where reg_DE_EN==0 and reg_DE_flush==0; both saturate at 32'hFFFFFFFF; not affected by anything but rst.
REQ-029 Macro undefined: no counter registers; bubble_cnt and hold_cnt tied to 0.

Verification
REQ-030 Reset mid-run: load PC_ID=0x100, then assert rst between edges -> outputs clear asynchronously, inst_EXE=0x00000013.
REQ-031 Forward sweep: rs1_data_ID=1, ALUout_EXE=2, ALUout_MEM=3, Datain_MEM=4, forward_ctrl_A 00/01/10/11 -> rs1_data_EXE 1/2/3/4 one cycle later; same for B.
REQ-032 Load-use stall: reg_DE_EN=1, reg_DE_flush=1 with inst_ID=0x00A00093 -> inst_EXE=0x00000013, reg_write_EXE=0, PC_EXE=PC_ID.
REQ-033 Hold: load inst 0x002081B3, then reg_DE_EN=0 for 3 cycles while inputs change -> outputs constant; hold_cnt=3 (macro on), 0 (macro off).
REQ-034 Simultaneous flush and EN=0 -> bubble inserted; bubble_cnt+1, hold_cnt unchanged.
REQ-035 Saturation (macro on): force bubble_cnt to 0xFFFFFFFE, two flushes -> reads 0xFFFFFFFF.
